// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the sequential multiplier
package mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

  localparam int MULT_ITERS = 32;
  localparam int CNT_W      = $clog2(MULT_ITERS);

endpackage

// File: rtl/add32_carry.sv
// rtl/add32_carry.sv - 32-bit adder with carry-out for the shift-add iteration
module add32_carry (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        carry
);

  // 33-bit add so the carry out of the high accumulator half is kept
  always_comb begin
    {carry, sum} = {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/mult32_seq.sv
// rtl/mult32_seq.sv - iterative 32x32 shift-add multiplier with start/done handshake
module mult32_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MULT_ITERS - 1);

  mult_state_t        state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic               neg;
  logic [CNT_W-1:0]   count;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // 0x80000000 negates to itself; read as unsigned it is still the right magnitude
  assign a_mag = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag = (signed_op && b[WIDTH-1]) ? -b : b;

  assign addend = mplier[0] ? mcand : '0;

  add32_carry u_add (
    .a     (acc[2*WIDTH-1:WIDTH]),
    .b     (addend),
    .sum   (sum),
    .carry (carry)
  );

  // carry re-enters at the top as {carry, acc} shifts right one place
  assign acc_next = {carry, sum, acc[WIDTH-1:1]};
  assign product  = neg ? -acc_next : acc_next;

  assign ready = (state == IDLE) || (state == DONE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

  // control FSM plus datapath registers; hi/lo load only on the final iteration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            count  <= '0;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
          if (count == LAST_ITER) begin
            hi    <= product[2*WIDTH-1:WIDTH];
            lo    <= product[WIDTH-1:0];
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult32_seq.sv
// tb/tb_mult32_seq.sv - self-checking bench for mult32_seq
module tb_mult32_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ready, busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  mult32_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .signed_op (signed_op),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] ref_product(input logic s, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = 64'(x);
    uy = 64'(y);
    return ux * uy;
  endfunction

  // Reference: a multiply is busy for 32 clocks after acceptance, then shows
  // its product for one done cycle; the result persists until the next one.
  int          m_phase = 0;   // 0 idle, 1 running, 2 done
  int          m_left = 0;
  logic [63:0] m_prod = '0;
  logic [63:0] m_out = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0;
      m_left  = 0;
      m_out   = '0;
    end else if (m_phase == 1) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_phase = 2;
        m_out   = m_prod;
      end
    end else if (start) begin
      m_prod  = ref_product(signed_op, a, b);
      m_left  = 32;
      m_phase = 1;
    end else begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", 64'(ready), 64'(m_phase != 1));
      check("busy",  64'(busy),  64'(m_phase == 1));
      check("done",  64'(done),  64'(m_phase == 2));
      check("hi",    64'(hi),    64'(m_out[63:32]));
      check("lo",    64'(lo),    64'(m_out[31:0]));
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      n++;
      #1;
    end
  endtask

  task automatic run_mult(input logic s, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    start = 1'b1; signed_op = s; a = x; b = y;
    @(posedge clk);
    #2 start = 1'b0;
    wait_done(n);
    check("latency", 64'(n), 64'd32);
    check("vec_hi", 64'(hi), 64'(exp_hi));
    check("vec_lo", 64'(lo), 64'(exp_lo));
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    #1;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_done",  64'(done),  64'd0);
    check("rst_hi",    64'(hi),    64'd0);
    check("rst_lo",    64'(lo),    64'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #2;

    run_mult(1'b0, 32'd3,        32'd5,        32'h00000000, 32'h0000000F);
    run_mult(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_mult(1'b1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA);
    run_mult(1'b0, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA);
    run_mult(1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_mult(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
    run_mult(1'b1, 32'd7,        32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD);
    run_mult(1'b1, 32'h80000000, 32'd1,        32'hFFFFFFFF, 32'h80000000);

    // start pulsed in the middle of RUN must be ignored
    start = 1'b1; signed_op = 1'b0; a = 32'd3; b = 32'd5;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 start = 1'b1; a = 32'h12345678; b = 32'h9ABCDEF0;
    @(posedge clk);
    #2 start = 1'b0;
    n = 11;
    while (!done && n < 40) begin
      @(posedge clk);
      n++;
      #1;
    end
    check("ign_latency", 64'(n), 64'd32);
    check("ign_hi", 64'(hi), 64'd0);
    check("ign_lo", 64'(lo), 64'h0000000F);
    @(posedge clk);
    #2;

    // start held through DONE: back-to-back issue, done 33 cycles apart
    start = 1'b1; signed_op = 1'b0; a = 32'd2; b = 32'd7;
    @(posedge clk);
    #2 a = 32'd4; b = 32'd4;
    wait_done(n);
    check("b2b_first_latency", 64'(n), 64'd32);
    check("b2b_first_lo", 64'(lo), 64'd14);
    n = 0;
    @(posedge clk);
    n++;
    #1;
    check("b2b_done_drop", 64'(done), 64'd0);
    check("b2b_busy", 64'(busy), 64'd1);
    start = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk);
      n++;
      #1;
    end
    check("b2b_interval", 64'(n), 64'd33);
    check("b2b_second_lo", 64'(lo), 64'd16);
    @(posedge clk);
    #2;

    // asynchronous reset at iteration 16 aborts the multiply
    start = 1'b1; signed_op = 1'b0; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (16) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_ready", 64'(ready), 64'd1);
    check("arst_busy",  64'(busy),  64'd0);
    check("arst_done",  64'(done),  64'd0);
    check("arst_hi",    64'(hi),    64'd0);
    check("arst_lo",    64'(lo),    64'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) n++;
    end
    check("arst_no_done", 64'(n), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "watchdog");
  end

endmodule
